// File: rtl/conversion_ctrl.sv
`timescale 1ns/1ps
// conversion_ctrl
//   Sequencer in front of the combinational unit-conversion datapath.
//   It accepts a raw sample, holds the user-selected output unit and drives
//   the datapath with a stable operand for CONV_LAT cycles. It then captures
//   the result and offers it downstream. When the selected unit changes, it
//   re-converts the last held sample so the display refreshes without a new
//   measurement.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   in_data/valid/ready     raw sample handshake (upstream)
//   unit_next               one-cycle pulse: advance the selected unit
//   unit_sel                currently selected unit
//   conv_data/conv_unit     operands to the conversion datapath
//   conv_result             result from the conversion datapath
//   out_data/unit/valid/ready  converted result handshake (downstream)
//   busy                    sequencer is not idle
module conversion_ctrl #(
  parameter int DATA_W    = 19,
  parameter int NUM_UNITS = 4,
  parameter int CONV_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              unit_next,
  output logic [1:0]        unit_sel,
  output logic [DATA_W-1:0] conv_data,
  output logic [1:0]        conv_unit,
  input  logic [DATA_W-1:0] conv_result,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_unit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int CNT_W = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_LAT - 1);
  localparam logic [1:0]       UNIT_MAX = 2'(NUM_UNITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_OUTPUT
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        unit_q, unit_d;
  logic [1:0]        last_unit_q, last_unit_d;
  logic              have_q, have_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] conv_data_q, conv_data_d;
  logic [1:0]        conv_unit_q, conv_unit_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]        out_unit_q, out_unit_d;
  logic              out_valid_q, out_valid_d;

  // NOTE: every variable gets its hold value first, so no path through this
  // block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    unit_d      = unit_q;
    last_unit_d = last_unit_q;
    have_d      = have_q;
    cnt_d       = cnt_q;
    conv_data_d = conv_data_q;
    conv_unit_d = conv_unit_q;
    out_data_d  = out_data_q;
    out_unit_d  = out_unit_q;
    out_valid_d = out_valid_q;

    // The unit selector runs independently of the sequencer state.
    if (unit_next) begin
      unit_d = (unit_q == UNIT_MAX) ? 2'd0 : unit_q + 2'd1;
    end

    unique case (state_q)
      ST_IDLE: begin
        // A new sample wins over a refresh; both latch the pre-increment unit.
        if (in_valid) begin
          conv_data_d = in_data;
          conv_unit_d = unit_q;
          have_d      = 1'b1;
          cnt_d       = '0;
          state_d     = ST_CONVERT;
        end else if (have_q && (unit_q != last_unit_q)) begin
          conv_unit_d = unit_q;
          cnt_d       = '0;
          state_d     = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (cnt_q == CNT_LAST) begin
          out_data_d  = conv_result;
          out_unit_d  = conv_unit_q;
          out_valid_d = 1'b1;
          state_d     = ST_OUTPUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_OUTPUT: begin
        // Remembering the delivered unit is what later triggers (or
        // suppresses) a refresh; multiple unit pulses collapse into one.
        if (out_ready) begin
          out_valid_d = 1'b0;
          last_unit_d = out_unit_q;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, and reset is checked synchronously here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      unit_q      <= '0;
      last_unit_q <= '0;
      have_q      <= 1'b0;
      cnt_q       <= '0;
      conv_data_q <= '0;
      conv_unit_q <= '0;
      out_data_q  <= '0;
      out_unit_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      unit_q      <= unit_d;
      last_unit_q <= last_unit_d;
      have_q      <= have_d;
      cnt_q       <= cnt_d;
      conv_data_q <= conv_data_d;
      conv_unit_q <= conv_unit_d;
      out_data_q  <= out_data_d;
      out_unit_q  <= out_unit_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign unit_sel  = unit_q;
  assign conv_data = conv_data_q;
  assign conv_unit = conv_unit_q;
  assign out_data  = out_data_q;
  assign out_unit  = out_unit_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_conversion_ctrl.sv
`timescale 1ns/1ps
// Testbench for conversion_ctrl. Two instances share the stimulus:
// index 0 uses CONV_LAT=1 and index 1 uses CONV_LAT=3. A transaction-level
// model predicts every output on every cycle. Directed scenarios pin the
// model with literal values, and then a randomized phase runs.
module tb_conversion_ctrl;

  localparam int DATA_W = 19;
  localparam int MASK   = (1 << DATA_W) - 1;
  localparam int LAT [2] = '{1, 3};

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              unit_next;
  logic              out_ready;

  logic              o_in_ready [2];
  logic [1:0]        o_unit_sel [2];
  logic [DATA_W-1:0] o_conv_data[2];
  logic [1:0]        o_conv_unit[2];
  logic [DATA_W-1:0] o_conv_res [2];
  logic [DATA_W-1:0] o_out_data [2];
  logic [1:0]        o_out_unit [2];
  logic              o_out_valid[2];
  logic              o_busy     [2];

  // Conversion datapath stand-in: result = data * (unit + 1).
  for (genvar g = 0; g < 2; g++) begin : g_conv
    assign o_conv_res[g] = DATA_W'(32'(o_conv_data[g]) * (32'(o_conv_unit[g]) + 32'd1));
  end

  conversion_ctrl #(.DATA_W(DATA_W), .NUM_UNITS(4), .CONV_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(o_in_ready[0]), .unit_next(unit_next), .unit_sel(o_unit_sel[0]),
    .conv_data(o_conv_data[0]), .conv_unit(o_conv_unit[0]), .conv_result(o_conv_res[0]),
    .out_data(o_out_data[0]), .out_unit(o_out_unit[0]), .out_valid(o_out_valid[0]),
    .out_ready(out_ready), .busy(o_busy[0])
  );

  conversion_ctrl #(.DATA_W(DATA_W), .NUM_UNITS(4), .CONV_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(o_in_ready[1]), .unit_next(unit_next), .unit_sel(o_unit_sel[1]),
    .conv_data(o_conv_data[1]), .conv_unit(o_conv_unit[1]), .conv_result(o_conv_res[1]),
    .out_data(o_out_data[1]), .out_unit(o_out_unit[1]), .out_valid(o_out_valid[1]),
    .out_ready(out_ready), .busy(o_busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Transaction-level model. m_timer counts the remaining conversion cycles
  // of the job in flight. When it reaches zero, the result is sample*(unit+1).
  int m_sample[2], m_have[2], m_cur[2], m_last[2], m_timer[2];
  int m_job_unit[2], m_ov[2], m_od[2], m_ou[2];

  function automatic bit m_idle(int k);
    return (m_timer[k] == 0) && (m_ov[k] == 0);
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_sample[k] = 0; m_have[k] = 0; m_cur[k] = 0; m_last[k] = 0; m_timer[k] = 0;
      m_job_unit[k] = 0; m_ov[k] = 0; m_od[k] = 0; m_ou[k] = 0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_sample[k] = 0; m_have[k] = 0; m_cur[k] = 0; m_last[k] = 0; m_timer[k] = 0;
        m_job_unit[k] = 0; m_ov[k] = 0; m_od[k] = 0; m_ou[k] = 0;
      end else begin
        if (m_idle(k)) begin
          if (in_valid) begin
            m_sample[k]   = int'(in_data);
            m_have[k]     = 1;
            m_job_unit[k] = m_cur[k];
            m_timer[k]    = LAT[k];
          end else if (m_have[k] != 0 && m_cur[k] != m_last[k]) begin
            m_job_unit[k] = m_cur[k];
            m_timer[k]    = LAT[k];
          end
        end else if (m_timer[k] > 0) begin
          m_timer[k]--;
          if (m_timer[k] == 0) begin
            m_ov[k] = 1;
            m_od[k] = (m_sample[k] * (m_job_unit[k] + 1)) & MASK;
            m_ou[k] = m_job_unit[k];
          end
        end else if (out_ready) begin
          m_ov[k]   = 0;
          m_last[k] = m_ou[k];
        end
        if (unit_next) m_cur[k] = (m_cur[k] + 1) % 4;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("u%0d in_ready", k),  32'(o_in_ready[k]),  32'(m_idle(k)));
        check($sformatf("u%0d busy", k),      32'(o_busy[k]),      32'(!m_idle(k)));
        check($sformatf("u%0d unit_sel", k),  32'(o_unit_sel[k]),  32'(m_cur[k]));
        check($sformatf("u%0d conv_data", k), 32'(o_conv_data[k]), 32'(m_sample[k]));
        check($sformatf("u%0d conv_unit", k), 32'(o_conv_unit[k]), 32'(m_job_unit[k]));
        check($sformatf("u%0d out_valid", k), 32'(o_out_valid[k]), 32'(m_ov[k]));
        check($sformatf("u%0d out_data", k),  32'(o_out_data[k]),  32'(m_od[k]));
        check($sformatf("u%0d out_unit", k),  32'(o_out_unit[k]),  32'(m_ou[k]));
      end
    end
  end

  // Handshake log: results delivered by instance 0, count for instance 1.
  int hs_data[$];
  int hs_unit[$];
  int hs3_cnt = 0;

  always @(negedge clk) begin
    if (rst_n && out_ready && o_out_valid[0] === 1'b1) begin
      hs_data.push_back(int'(o_out_data[0]));
      hs_unit.push_back(int'(o_out_unit[0]));
    end
    if (rst_n && out_ready && o_out_valid[1] === 1'b1) hs3_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    hs_data.delete();
    hs_unit.delete();
    hs3_cnt = 0;
  endtask

  task automatic expect_log(input string name, input int d0, input int u0,
                            input int d1, input int u1, input int n);
    check({name, " count"}, 32'(hs_data.size()), 32'(n));
    if (hs_data.size() >= 1) begin
      check({name, " r0 data"}, 32'(hs_data[0]), 32'(d0));
      check({name, " r0 unit"}, 32'(hs_unit[0]), 32'(u0));
    end
    if (n >= 2 && hs_data.size() >= 2) begin
      check({name, " r1 data"}, 32'(hs_data[1]), 32'(d1));
      check({name, " r1 unit"}, 32'(hs_unit[1]), 32'(u1));
    end
  endtask

  int exp_d[4] = '{260, 390, 520, 130};
  int exp_u[4] = '{1, 2, 3, 0};

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b1; in_data = 19'd777; unit_next = 1'b0; out_ready = 1'b1;

    // 1. Reset held for two edges with in_valid high: nothing is captured.
    tick();
    chk_en = 1'b1;
    tick();
    check("reset out_valid", 32'(o_out_valid[0]), 32'd0);
    check("reset unit_sel",  32'(o_unit_sel[0]),  32'd0);
    check("reset out_data",  32'(o_out_data[0]),  32'd0);
    check("reset busy",      32'(o_busy[0]),      32'd0);
    check("reset in_ready",  32'(o_in_ready[0]),  32'd1);
    check("reset conv_data", 32'(o_conv_data[0]), 32'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    tick();

    // 2. Single sample 130 at unit 0.
    in_data = 19'd130; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single convert out_valid", 32'(o_out_valid[0]), 32'd0);
    check("single convert in_ready",  32'(o_in_ready[0]),  32'd0);
    tick();
    check("single out_valid", 32'(o_out_valid[0]), 32'd1);
    check("single out_data",  32'(o_out_data[0]),  32'd130);
    check("single out_unit",  32'(o_out_unit[0]),  32'd0);
    tick();
    check("single out_valid drop", 32'(o_out_valid[0]), 32'd0);
    repeat (4) tick();

    // 3. Unit cycling with refresh, including the 3->0 wrap.
    clear_log();
    for (int p = 0; p < 4; p++) begin
      unit_next = 1'b1;
      tick();
      unit_next = 1'b0;
      repeat (6) tick();
      check($sformatf("refresh %0d count", p), 32'(hs_data.size()), 32'(p + 1));
      if (hs_data.size() == p + 1) begin
        check($sformatf("refresh %0d data", p), 32'(hs_data[p]), 32'(exp_d[p]));
        check($sformatf("refresh %0d unit", p), 32'(hs_unit[p]), 32'(exp_u[p]));
      end
    end

    // 4. Backpressure: the result is held for 10 cycles, then one handshake.
    out_ready = 1'b0; in_data = 19'd130; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("bp out_valid", 32'(o_out_valid[0]), 32'd1);
      check("bp out_data",  32'(o_out_data[0]),  32'd130);
      check("bp in_ready",  32'(o_in_ready[0]),  32'd0);
      tick();
    end
    clear_log();
    out_ready = 1'b1;
    tick();
    check("bp release out_valid", 32'(o_out_valid[0]), 32'd0);
    check("bp release busy",      32'(o_busy[0]),      32'd0);
    repeat (4) tick();
    check("bp handshakes", 32'(hs_data.size()), 32'd1);

    // 5a. unit_next during CONVERT: old unit first, then a single refresh.
    clear_log();
    in_data = 19'd100; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; unit_next = 1'b1;
    tick();
    unit_next = 1'b0;
    repeat (10) tick();
    expect_log("collide convert", 100, 0, 200, 1, 2);

    // 5b. unit_next together with in_valid: sample uses old unit, then refresh.
    clear_log();
    in_data = 19'd50; in_valid = 1'b1; unit_next = 1'b1;
    tick();
    in_valid = 1'b0; unit_next = 1'b0;
    repeat (10) tick();
    expect_log("collide accept", 100, 1, 150, 2, 2);

    // 6. Reset during OUTPUT with a refresh pending: everything is discarded.
    out_ready = 1'b0; in_data = 19'd9; in_valid = 1'b1; unit_next = 1'b1;
    tick();
    in_valid = 1'b0; unit_next = 1'b0;
    tick();
    check("midreset before out_valid", 32'(o_out_valid[0]), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset out_valid", 32'(o_out_valid[0]), 32'd0);
    check("midreset unit_sel",  32'(o_unit_sel[0]),  32'd0);
    clear_log();
    out_ready = 1'b1;
    repeat (8) tick();
    check("midreset no result u0", 32'(hs_data.size()), 32'd0);
    check("midreset no result u1", 32'(hs3_cnt), 32'd0);
    check("midreset idle", 32'(o_busy[1]), 32'd0);

    // CONV_LAT=3: accept edge through out_valid spans 4 edges (bounded wait).
    in_data = 19'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (o_out_valid[1] !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("lat3 edges accept->valid", 32'(n + 1), 32'd4);
    check("lat3 out_data", 32'(o_out_data[1]), 32'd7);
    repeat (3) tick();

    // Randomized phase with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      in_valid  = ($urandom_range(0, 9) < 3);
      in_data   = DATA_W'($urandom_range(0, MASK));
      unit_next = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    rst_n = 1'b1; in_valid = 1'b0; unit_next = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/conversion_ctrl.md
# conversion_ctrl

- Sequencer in front of the combinational `conversion` unit-conversion datapath.
- Accepts raw 19-bit distance samples over a valid/ready handshake and holds the user-selected output unit, advanced by a one-cycle `unit_next` pulse.
- Drives `conversion` with a stable operand for a fixed settling window, captures its result, and presents it downstream over a second valid/ready handshake.
- When the unit changes, it re-converts the last held sample, so the display refreshes without a new measurement.

## Interface
Parameters:
- DATA_W, 19, sample/result width (matches `conversion`)
- NUM_UNITS, 4, number of selectable units; unit index is 2 bits
- CONV_LAT, 1, cycles operands are held on `conversion` before capture; must be ≥1

Ports:
- clk  in  1  clock; one clock domain, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_data  in  DATA_W  raw sample
- in_valid  in  1  sample valid
- in_ready  out  1  block can accept a sample
- unit_next  in  1  single-cycle pulse: advance selected unit
- unit_sel  out  2  currently selected unit (cur_unit)
- conv_data  out  DATA_W  operand to `conversion.data_in`
- conv_unit  out  2  operand to `conversion.convertTo`
- conv_result  in  DATA_W  from `conversion.data_out`
- out_data  out  DATA_W  converted result
- out_unit  out  2  unit of out_data
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- busy  out  1  state ≠ IDLE

## Operation
Reset:
- On rst_n=0 at a clock edge: state=IDLE, cur_unit=0, last_unit=0, have_sample=0, cnt=0.
- All output registers clear: conv_data=0, conv_unit=0, out_data=0, out_unit=0, out_valid=0.
- Reset mid-operation discards the held sample and any pending result.

Unit register:
- unit_next=1 at an edge sets cur_unit ← (cur_unit+1) mod NUM_UNITS in every state.
- Wrap: 3→0.
- unit_sel = cur_unit.

State machine (IDLE / CONVERT / OUTPUT):
- IDLE: in_ready=1.
  - If in_valid: conv_data←in_data, conv_unit←cur_unit (pre-increment value if unit_next coincides), have_sample←1, cnt←0 → CONVERT.
  - Else if have_sample && cur_unit≠last_unit: conv_unit←cur_unit, conv_data unchanged (refresh) → CONVERT.
  - A new sample has priority over a refresh.
- CONVERT: in_ready=0; conv_data/conv_unit held constant; cnt increments each cycle.
  - At the edge where cnt=CONV_LAT−1: out_data←conv_result, out_unit←conv_unit, out_valid←1 → OUTPUT.
- OUTPUT: in_ready=0; out_data/out_unit/out_valid held stable until out_ready=1.
  - On the handshake edge: out_valid←0, last_unit←out_unit → IDLE.
- Unit changes during CONVERT/OUTPUT do not alter the in-flight result. They produce a refresh from IDLE afterward if cur_unit≠last_unit.
- Multiple unit_next pulses during one conversion collapse to a single refresh using the final cur_unit.
- No arithmetic in this block; data passes unmodified. cnt width is max(1, clog2(CONV_LAT)).

## Timing
- in_ready and busy are combinational from state; all other outputs are registered.
- Accept at edge E0 → CONVERT occupies E0+1 … E0+CONV_LAT → out_valid=1 after edge E0+CONV_LAT.
- With out_ready=1, the result handshakes at edge E0+CONV_LAT+1; in_ready=1 in the next cycle.
- Peak throughput: one sample per CONV_LAT+2 cycles.
- Refresh latency from IDLE with unit changed: same as a new sample, with the trigger edge in place of E0.
- out_valid never deasserts without out_ready; out_data never changes while out_valid=1.

## Test plan
Bench `conversion` model: conv_result = conv_data·(conv_unit+1).

1. Reset: hold rst_n=0 for 2 edges with in_valid=1 → out_valid=0, unit_sel=0, out_data=0, busy=0, in_ready=1; no capture occurs.
2. Single sample: in_data=130, unit 0, out_ready=1, CONV_LAT=1 → out_valid for exactly 1 cycle, 2 cycles after the accept edge, with out_data=130, out_unit=0.
3. Unit cycling and refresh: after test 2, pulse unit_next 3 times with idle gaps → results 260/1, 390/2, 520/3; a 4th pulse wraps to 0 → 130/0. in_valid stays 0 throughout.
4. Backpressure: out_ready=0 for 10 cycles → out_valid and out_data=130 held and in_ready=0 for the whole window; release → one handshake, then IDLE.
5. Collisions:
   - unit_next during CONVERT with out_ready=1 → first result uses the old unit, then one refresh result with the new unit.
   - unit_next in the same cycle as in_valid → sample uses the old unit, followed by a refresh.
6. Mid-operation reset and CONV_LAT=3: assert rst_n=0 during OUTPUT → out_valid=0 next cycle and no refresh afterward. With CONV_LAT=3, accept→out_valid takes 4 edges.
